// File: rtl/alu_rr_sequencer_if.sv
// Bundles the two request channels, the ALU drive/return lines and the response
// channel of alu_rr_sequencer; slave is the sequencer side, master the surrounding system.
interface alu_rr_sequencer_if;
  logic        req0_valid;
  logic [3:0]  req0_op;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [3:0]  req1_op;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic        req1_ready;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [15:0] alu_out;
  logic        alu_flag_c;
  logic        alu_flag_z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_c;
  logic        rsp_z;
  logic        rsp_err;
  logic        busy;
  logic [15:0] ops_done;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_out, alu_flag_c, alu_flag_z, rsp_ready,
    output req0_ready, req1_ready, alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data, rsp_c, rsp_z, rsp_err, busy, ops_done
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_out, alu_flag_c, alu_flag_z, rsp_ready,
    input  req0_ready, req1_ready, alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data, rsp_c, rsp_z, rsp_err, busy, ops_done
  );
endinterface

// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Define ALU_DIVZERO_CHK_EN to short-circuit div/mod by zero into an error response.
module alu_rr_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_rr_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(ALU_LAT - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic        r_lastGrant;
  logic [3:0]  r_waitCnt;
  logic [3:0]  r_aluOp;
  logic [7:0]  r_aluA;
  logic [7:0]  r_aluB;
  logic        r_rspId;
  logic [15:0] r_rspData;
  logic        r_rspC;
  logic        r_rspZ;
  logic [15:0] r_opsDone;

  logic        w_grant1;
  logic        w_ready0;
  logic        w_ready1;
  logic        w_accept;
  logic [3:0]  w_selOp;
  logic [7:0]  w_selA;
  logic [7:0]  w_selB;
  logic        w_divZero;
  logic        w_captureNow;
  logic        w_rspFire;

  // Requester 1 wins alone, or on contention when requester 0 was served last.
  assign w_grant1     = bus.req1_valid & (~bus.req0_valid | ~r_lastGrant);
  assign w_ready0     = (r_state == IDLE) & bus.req0_valid & ~w_grant1;
  assign w_ready1     = (r_state == IDLE) & w_grant1;
  assign w_accept     = w_ready0 | w_ready1;
  assign w_selOp      = w_grant1 ? bus.req1_op : bus.req0_op;
  assign w_selA       = w_grant1 ? bus.req1_a  : bus.req0_a;
  assign w_selB       = w_grant1 ? bus.req1_b  : bus.req0_b;
  assign w_captureNow = (r_state == ISSUE) && (r_waitCnt == LAST_CNT);
  assign w_rspFire    = (r_state == RESP) & bus.rsp_ready;

`ifdef ALU_DIVZERO_CHK_EN
  logic r_rspErr;

  assign w_divZero = ((w_selOp == 4'b0011) || (w_selOp == 4'b0100)) && (w_selB == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspErr <= 1'b0;
    end else if (w_accept) begin
      r_rspErr <= w_divZero;
    end
  end

  assign bus.rsp_err = r_rspErr;
`else
  assign w_divZero   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = w_divZero ? RESP : ISSUE;
      ISSUE:   if (w_captureNow) w_nextState = RESP;
      RESP:    if (bus.rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Carry is only meaningful for add/sub, so it is masked for every other opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastGrant <= 1'b1;
      r_waitCnt   <= 4'd0;
      r_aluOp     <= 4'd0;
      r_aluA      <= 8'd0;
      r_aluB      <= 8'd0;
      r_rspId     <= 1'b0;
      r_rspData   <= 16'd0;
      r_rspC      <= 1'b0;
      r_rspZ      <= 1'b0;
      r_opsDone   <= 16'd0;
    end else begin
      if (w_accept) begin
        r_aluOp     <= w_selOp;
        r_aluA      <= w_selA;
        r_aluB      <= w_selB;
        r_rspId     <= w_grant1;
        r_lastGrant <= w_grant1;
        r_waitCnt   <= 4'd0;
        if (w_divZero) begin
          r_rspData <= 16'hFFFF;
          r_rspC    <= 1'b0;
          r_rspZ    <= 1'b0;
        end
      end
      if (r_state == ISSUE) begin
        r_waitCnt <= r_waitCnt + 4'd1;
        if (w_captureNow) begin
          r_rspData <= bus.alu_out;
          r_rspZ    <= bus.alu_flag_z;
          r_rspC    <= ((r_aluOp == 4'b0000) || (r_aluOp == 4'b0001)) & bus.alu_flag_c;
        end
      end
      if (w_rspFire) begin
        r_opsDone <= r_opsDone + 16'd1;
      end
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.alu_op     = r_aluOp;
  assign bus.alu_a      = r_aluA;
  assign bus.alu_b      = r_aluB;
  assign bus.rsp_valid  = (r_state == RESP);
  assign bus.rsp_id     = r_rspId;
  assign bus.rsp_data   = r_rspData;
  assign bus.rsp_c      = r_rspC;
  assign bus.rsp_z      = r_rspZ;
  assign bus.busy       = (r_state != IDLE);
  assign bus.ops_done   = r_opsDone;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Scoreboard bench for alu_rr_sequencer: one instance with ALU_LAT=1, one with ALU_LAT=4,
// each driven by a behavioural ALU; expected responses are queued at accept time.
module tb_alu_rr_sequencer;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
    logic        c;
    logic        z;
    logic        err;
    logic [4:0]  lat;
  } exp_t;

`ifdef ALU_DIVZERO_CHK_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   checkCount = 0;
  int   passCount = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t expReq[2][2];
  int   acceptCycle[2];
  int   expOps[2];
  bit   opsPending[2];
  bit   prevValid[2];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  alu_rr_sequencer_if b1();
  alu_rr_sequencer_if b4();

  alu_rr_sequencer #(.ALU_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  alu_rr_sequencer #(.ALU_LAT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  // Behavioural ALU: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 and, 6 or, 7 xor, else pass A.
  // Non add/sub ops raise carry so the sequencer's masking is visible.
  function automatic logic [17:0] aluModel(logic [3:0] op, logic [7:0] a, logic [7:0] b);
    logic [15:0] res;
    logic        c;
    c = 1'b1;
    case (op)
      4'h0: begin res = 16'(a) + 16'(b); c = res[8]; end
      4'h1: begin res = 16'(a) - 16'(b); c = (a < b); end
      4'h2: res = 16'(a) * 16'(b);
      4'h3: res = (b == 8'h00) ? 16'hFFFF : 16'(a / b);
      4'h4: res = (b == 8'h00) ? 16'hFFFF : 16'(a % b);
      4'h5: res = 16'(a & b);
      4'h6: res = 16'(a | b);
      4'h7: res = 16'(a ^ b);
      default: res = 16'(a);
    endcase
    return {c, (res == 16'h0000), res};
  endfunction

  assign {b1.alu_flag_c, b1.alu_flag_z, b1.alu_out} = aluModel(b1.alu_op, b1.alu_a, b1.alu_b);
  assign {b4.alu_flag_c, b4.alu_flag_z, b4.alu_out} = aluModel(b4.alu_op, b4.alu_a, b4.alu_b);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
  endtask

  function automatic int sbSize(int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t sbFront(int d);
    return (d == 0) ? sb0[0] : sb1[0];
  endfunction

  task automatic sbPush(input int d, input exp_t e);
    if (d == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  task automatic sbPop(input int d, output exp_t e);
    if (d == 0) e = sb0.pop_front();
    else e = sb1.pop_front();
  endtask

  // Accepts queue the expected response; handshakes pop and compare it.
  task automatic monitorStep(input int d, input logic v, input logic rr, input logic id,
                             input logic [15:0] data, input logic c, input logic z,
                             input logic err, input logic busy, input logic [15:0] ops,
                             input logic r0, input logic r1);
    exp_t e;
    if (opsPending[d]) begin
      opsPending[d] = 1'b0;
      checkOutput($sformatf("opsDone%0d", d), 32'(ops), expOps[d]);
      checkOutput($sformatf("idleAfterRsp%0d", d), 32'(busy), 0);
    end
    if (r0 | r1) begin
      checkOutput($sformatf("oneReady%0d", d), 32'(r0 & r1), 0);
      sbPush(d, expReq[d][r1]);
      acceptCycle[d] = cycle;
    end
    if (v && !prevValid[d]) begin
      if (sbSize(d) == 0) checkOutput($sformatf("unexpectedRsp%0d", d), 1, 0);
      else checkOutput($sformatf("latency%0d", d), 32'(cycle - acceptCycle[d]), 32'(sbFront(d).lat));
    end
    prevValid[d] = v;
    if (v && rr) begin
      if (sbSize(d) == 0) begin
        checkOutput($sformatf("unexpectedHandshake%0d", d), 1, 0);
      end else begin
        sbPop(d, e);
        checkOutput($sformatf("rspId%0d", d), 32'(id), 32'(e.id));
        checkOutput($sformatf("rspData%0d", d), 32'(data), 32'(e.data));
        checkOutput($sformatf("rspC%0d", d), 32'(c), 32'(e.c));
        checkOutput($sformatf("rspZ%0d", d), 32'(z), 32'(e.z));
        checkOutput($sformatf("rspErr%0d", d), 32'(err), 32'(e.err));
        expOps[d]++;
        opsPending[d] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      monitorStep(0, b1.rsp_valid, b1.rsp_ready, b1.rsp_id, b1.rsp_data, b1.rsp_c, b1.rsp_z,
                  b1.rsp_err, b1.busy, b1.ops_done, b1.req0_ready, b1.req1_ready);
      monitorStep(1, b4.rsp_valid, b4.rsp_ready, b4.rsp_id, b4.rsp_data, b4.rsp_c, b4.rsp_z,
                  b4.rsp_err, b4.busy, b4.ops_done, b4.req0_ready, b4.req1_ready);
    end
  end

  function automatic logic getReady(int d, int id);
    if (d == 0) return (id == 0) ? b1.req0_ready : b1.req1_ready;
    return (id == 0) ? b4.req0_ready : b4.req1_ready;
  endfunction

  function automatic logic getBusy(int d);
    return (d == 0) ? b1.busy : b4.busy;
  endfunction

  task automatic setReq(input int d, input int id, input logic v, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b);
    if (d == 0 && id == 0) begin b1.req0_valid = v; b1.req0_op = op; b1.req0_a = a; b1.req0_b = b; end
    else if (d == 0)       begin b1.req1_valid = v; b1.req1_op = op; b1.req1_a = a; b1.req1_b = b; end
    else if (id == 0)      begin b4.req0_valid = v; b4.req0_op = op; b4.req0_a = a; b4.req0_b = b; end
    else                   begin b4.req1_valid = v; b4.req1_op = op; b4.req1_a = a; b4.req1_b = b; end
  endtask

  // Presents one request, waits for its accept, then withdraws it.
  task automatic applyStimulus(input int d, input int id, input logic [3:0] op,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] data, input logic c, input logic z,
                               input logic err, input int lat);
    exp_t e;
    bit   got;
    e.id = id[0]; e.data = data; e.c = c; e.z = z; e.err = err; e.lat = lat[4:0];
    expReq[d][id] = e;
    setReq(d, id, 1'b1, op, a, b);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (getReady(d, id)) got = 1'b1;
    end
    checkOutput($sformatf("accepted%0d_%0d", d, id), 32'(got), 1);
    @(posedge clk); #1;
    setReq(d, id, 1'b0, op, a, b);
  endtask

  task automatic waitIdle(input int d);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk); #1;
      if (!getBusy(d) && sbSize(d) == 0 && !opsPending[d]) done = 1'b1;
    end
    checkOutput($sformatf("waitIdle%0d", d), 32'(done), 1);
    @(posedge clk); #1;
  endtask

  task automatic clearScoreboard();
    sb0.delete();
    sb1.delete();
    for (int d = 0; d < 2; d++) begin
      expOps[d] = 0;
      opsPending[d] = 1'b0;
      prevValid[d] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit got;
    int cnt;
    clearScoreboard();
    setReq(0, 0, 1'b0, 4'h0, 8'h00, 8'h00);
    setReq(0, 1, 1'b0, 4'h0, 8'h00, 8'h00);
    setReq(1, 0, 1'b0, 4'h0, 8'h00, 8'h00);
    setReq(1, 1, 1'b0, 4'h0, 8'h00, 8'h00);
    b1.rsp_ready = 1'b1;
    b4.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetBusy", 32'(b1.busy), 0);
    checkOutput("resetRspValid", 32'(b1.rsp_valid), 0);
    checkOutput("resetOpsDone", 32'(b1.ops_done), 0);
    checkOutput("resetAluOp", 32'(b1.alu_op), 0);
    checkOutput("resetAluA", 32'(b1.alu_a), 0);
    checkOutput("resetRspData", 32'(b1.rsp_data), 0);
    checkOutput("resetBusy4", 32'(b4.busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single add request");
    applyStimulus(0, 0, 4'h0, 8'hF0, 8'h20, 16'h0110, 1'b1, 1'b0, 1'b0, 2);
    waitIdle(0);
    applyStimulus(0, 1, 4'h1, 8'h03, 8'h05, 16'hFFFE, 1'b1, 1'b0, 1'b0, 2);
    waitIdle(0);

    $display("[TB] contention and/or");
    expReq[0][0] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 5'd2};
    expReq[0][1] = '{1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0, 5'd2};
    setReq(0, 0, 1'b1, 4'h5, 8'h0F, 8'hF0);
    setReq(0, 1, 1'b1, 4'h6, 8'h0F, 8'hF0);
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (b1.req0_ready | b1.req1_ready) got = 1'b1;
      end
      checkOutput($sformatf("grantOrder%0d", g), got ? 32'(b1.req1_ready) : 32'd2, 32'(g % 2));
      @(posedge clk); #1;
    end
    setReq(0, 0, 1'b0, 4'h0, 8'h00, 8'h00);
    setReq(0, 1, 1'b0, 4'h0, 8'h00, 8'h00);
    waitIdle(0);

    $display("[TB] backpressure with multiply");
    b1.rsp_ready = 1'b0;
    applyStimulus(0, 0, 4'h2, 8'hFF, 8'h02, 16'h01FE, 1'b0, 1'b0, 1'b0, 2);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (b1.rsp_valid) got = 1'b1;
    end
    checkOutput("bpRspArrives", 32'(got), 1);
    @(posedge clk); #1;
    setReq(0, 0, 1'b1, 4'h0, 8'h01, 8'h01);
    setReq(0, 1, 1'b1, 4'h0, 8'h02, 8'h02);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bpNoReady", 32'(b1.req0_ready | b1.req1_ready), 0);
      checkOutput("bpBusy", 32'(b1.busy), 1);
      checkOutput("bpValid", 32'(b1.rsp_valid), 1);
      checkOutput("bpData", 32'(b1.rsp_data), 32'h01FE);
      @(posedge clk); #1;
    end
    setReq(0, 0, 1'b0, 4'h0, 8'h00, 8'h00);
    setReq(0, 1, 1'b0, 4'h0, 8'h00, 8'h00);
    b1.rsp_ready = 1'b1;
    waitIdle(0);

    $display("[TB] ALU_LAT=4 subtract");
    applyStimulus(1, 0, 4'h1, 8'h05, 8'h05, 16'h0000, 1'b0, 1'b1, 1'b0, 5);
    waitIdle(1);

    $display("[TB] reset during issue");
    applyStimulus(1, 1, 4'h0, 8'h01, 8'h02, 16'h0003, 1'b0, 1'b0, 1'b0, 5);
    @(negedge clk);
    rst_n = 1'b0;
    clearScoreboard();
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (b4.rsp_valid) cnt++;
    end
    checkOutput("noRspAfterReset", cnt, 0);
    checkOutput("opsAfterReset4", 32'(b4.ops_done), 0);
    checkOutput("opsAfterReset1", 32'(b1.ops_done), 0);
    checkOutput("busyAfterReset4", 32'(b4.busy), 0);
    @(posedge clk); #1;

    $display("[TB] divide by zero");
    applyStimulus(0, 0, 4'h3, 8'h10, 8'h00, 16'hFFFF, 1'b0, 1'b0, DZ, DZ ? 1 : 2);
    waitIdle(0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
